// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between the IF stage and
// mem_ctrl. A hit returns one cycle after acceptance. A miss drives mem_ctrl's
// fetch port until the matching word returns. Any returned word fills its line.
module icache #(
  parameter int INDEX_W = 7
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_pc_i,
  input  logic        flush_i,
  output logic        if_ok_o,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_inst_pc_o,
  output logic        mem_fe_o,
  output logic [31:0] mem_fpc_o,
  input  logic [31:0] mem_inst_i,
  input  logic        mem_ok_i,
  input  logic [31:0] mem_pc_i
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 30 - INDEX_W;

  typedef enum logic {S_IDLE = 1'b0, S_MISS = 1'b1} state_e;

  state_e state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [31:0] miss_pc_q, miss_pc_d;
  logic        if_ok_q, if_ok_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] if_inst_pc_q, if_inst_pc_d;

  logic [INDEX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0]   rd_tag, wr_tag;
  logic               hit, accept, pc_match, complete;

  assign rd_idx = if_pc_i[INDEX_W+1:2];
  assign rd_tag = if_pc_i[31:INDEX_W+2];
  assign wr_idx = mem_pc_i[INDEX_W+1:2];
  assign wr_tag = mem_pc_i[31:INDEX_W+2];

  // Lookup reads the pre-fill array contents; a same-cycle fill is not forwarded.
  assign hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  // The if_ok cycle never accepts, capping hit throughput at one per two cycles.
  assign accept   = (state_q == S_IDLE) && if_req_i && !flush_i && !if_ok_q;
  assign pc_match = mem_ok_i && (mem_pc_i == miss_pc_q);
  assign complete = (state_q == S_MISS) && pc_match && !flush_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: flush always wins; a stale mem_ok leaves the miss pending
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept && !hit) state_d = S_MISS;
        S_MISS:  if (complete)       state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: drop the fetch request in the matching mem_ok cycle so
  // mem_ctrl does not relaunch the same fetch
  always_comb begin
    mem_fe_o = 1'b0;
    if (state_q == S_MISS && !flush_i && !pc_match) mem_fe_o = 1'b1;
  end

  // Response and miss-address next-state
  always_comb begin
    if_ok_d      = 1'b0;
    if_inst_d    = if_inst_q;
    if_inst_pc_d = if_inst_pc_q;
    miss_pc_d    = miss_pc_q;
    if (accept && hit) begin
      if_ok_d      = 1'b1;
      if_inst_d    = data_q[rd_idx];
      if_inst_pc_d = if_pc_i;
    end else if (accept) begin
      miss_pc_d    = if_pc_i;
    end else if (complete) begin
      if_ok_d      = 1'b1;
      if_inst_d    = mem_inst_i;
      if_inst_pc_d = mem_pc_i;
    end
  end

  // Response and miss-address registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if_ok_q      <= 1'b0;
      if_inst_q    <= '0;
      if_inst_pc_q <= '0;
      miss_pc_q    <= '0;
    end else begin
      if_ok_q      <= if_ok_d;
      if_inst_q    <= if_inst_d;
      if_inst_pc_q <= if_inst_pc_d;
      miss_pc_q    <= miss_pc_d;
    end
  end

  // Valid bits: the only cache state cleared by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       valid_q         <= '0;
    else if (mem_ok_i) valid_q[wr_idx] <= 1'b1;
  end

  // Tag/data fill on every returned word, whatever the FSM state
  always_ff @(posedge clk_i) begin
    if (mem_ok_i) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= mem_inst_i;
    end
  end

  assign if_ok_o      = if_ok_q;
  assign if_inst_o    = if_inst_q;
  assign if_inst_pc_o = if_inst_pc_q;
  assign mem_fpc_o    = miss_pc_q;

endmodule

// File: tb/tb_icache.sv
// Bench for icache: expected responses are queued when a request is driven and
// popped by a monitor whenever if_ok pulses.
module tb_icache;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_req_i = 1'b0;
  logic [31:0] if_pc_i = '0;
  logic        flush_i = 1'b0;
  logic        if_ok_o;
  logic [31:0] if_inst_o, if_inst_pc_o;
  logic        mem_fe_o;
  logic [31:0] mem_fpc_o;
  logic [31:0] mem_inst_i = '0;
  logic        mem_ok_i = 1'b0;
  logic [31:0] mem_pc_i = '0;

  icache #(.INDEX_W(7)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .if_req_i(if_req_i), .if_pc_i(if_pc_i),
    .flush_i(flush_i), .if_ok_o(if_ok_o), .if_inst_o(if_inst_o),
    .if_inst_pc_o(if_inst_pc_o), .mem_fe_o(mem_fe_o), .mem_fpc_o(mem_fpc_o),
    .mem_inst_i(mem_inst_i), .mem_ok_i(mem_ok_i), .mem_pc_i(mem_pc_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } resp_t;

  resp_t exp_q[$];
  int nc = 0;
  int nm = 0;
  logic prev_ok = 1'b0;

  // Scoreboard consumer: every if_ok pulse must match the oldest expectation
  always @(negedge clk_i) begin
    if (rst_ni && if_ok_o === 1'b1) begin
      nc++;
      if (prev_ok) begin
        nm++;
        $display("FAIL back_to_back_ok: if_ok high two cycles in a row at %0t", $time);
      end
      if (exp_q.size() == 0) begin
        nm++;
        $display("FAIL unexpected_ok: got inst=%h pc=%h, required no response", if_inst_o, if_inst_pc_o);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        if (if_inst_o !== e.inst || if_inst_pc_o !== e.pc) begin
          nm++;
          $display("FAIL resp: got inst=%h pc=%h, required inst=%h pc=%h",
                   if_inst_o, if_inst_pc_o, e.inst, e.pc);
        end
      end
    end
    prev_ok = (if_ok_o === 1'b1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    resp_t e;
    e.inst = inst;
    e.pc   = pc;
    exp_q.push_back(e);
  endtask

  // Full miss: accept, check fetch port, return matching word, see response
  task automatic req_miss(input logic [31:0] pc, input logic [31:0] inst);
    if_req_i = 1'b1; if_pc_i = pc;
    step();
    nc++;
    if (mem_fe_o !== 1'b1 || mem_fpc_o !== pc) begin
      nm++;
      $display("FAIL miss_fetch: got fe=%b fpc=%h, required fe=1 fpc=%h", mem_fe_o, mem_fpc_o, pc);
    end
    mem_ok_i = 1'b1; mem_pc_i = pc; mem_inst_i = inst;
    push(inst, pc);
    #1;
    nc++;
    if (mem_fe_o !== 1'b0) begin
      nm++;
      $display("FAIL fe_drop_on_ok: got fe=%b, required 0", mem_fe_o);
    end
    step();
    mem_ok_i = 1'b0; if_req_i = 1'b0;
    nc++;
    if (if_ok_o !== 1'b1) begin
      nm++;
      $display("FAIL miss_latency: got if_ok=%b, required 1", if_ok_o);
    end
    step();
  endtask

  task automatic req_hit(input logic [31:0] pc, input logic [31:0] inst);
    if_req_i = 1'b1; if_pc_i = pc;
    push(inst, pc);
    step();
    if_req_i = 1'b0;
    nc++;
    if (if_ok_o !== 1'b1 || mem_fe_o !== 1'b0) begin
      nm++;
      $display("FAIL hit_%h: got if_ok=%b fe=%b, required if_ok=1 fe=0", pc, if_ok_o, mem_fe_o);
    end
    step();
  endtask

  task automatic test_reset();
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #1;
    nc++;
    if (if_ok_o !== 1'b0 || if_inst_o !== 32'h0 || if_inst_pc_o !== 32'h0 ||
        mem_fe_o !== 1'b0 || mem_fpc_o !== 32'h0) begin
      nm++;
      $display("FAIL reset: got ok=%b inst=%h ipc=%h fe=%b fpc=%h, required all 0",
               if_ok_o, if_inst_o, if_inst_pc_o, mem_fe_o, mem_fpc_o);
    end
    step(); step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_miss_fill();
    req_miss(32'h0, 32'h0000_0013);
  endtask

  task automatic test_hit();
    req_hit(32'h0, 32'h0000_0013);
  endtask

  // 0x200 aliases 0x0 at INDEX_W=7: filling it evicts 0x0
  task automatic test_alias();
    req_miss(32'h200, 32'h0010_0093);
    req_hit(32'h200, 32'h0010_0093);
    req_miss(32'h0, 32'h0000_0013);
  endtask

  task automatic test_flush();
    if_req_i = 1'b1; if_pc_i = 32'h10;
    step();
    flush_i = 1'b1;
    #1;
    nc++;
    if (mem_fe_o !== 1'b0) begin
      nm++;
      $display("FAIL flush_fe: got fe=%b, required 0", mem_fe_o);
    end
    step();
    flush_i = 1'b0; if_pc_i = 32'h40;
    step();
    nc++;
    if (mem_fe_o !== 1'b1 || mem_fpc_o !== 32'h40) begin
      nm++;
      $display("FAIL redirect: got fe=%b fpc=%h, required fe=1 fpc=00000040", mem_fe_o, mem_fpc_o);
    end
    // stale return for 0x10: fills only, fetch for 0x40 stays up
    mem_ok_i = 1'b1; mem_pc_i = 32'h10; mem_inst_i = 32'hAAAA_0010;
    #1;
    nc++;
    if (mem_fe_o !== 1'b1) begin
      nm++;
      $display("FAIL stale_fe: got fe=%b, required 1", mem_fe_o);
    end
    step();
    mem_ok_i = 1'b0;
    nc++;
    if (if_ok_o !== 1'b0) begin
      nm++;
      $display("FAIL stale_ok: got if_ok=%b, required 0", if_ok_o);
    end
    mem_ok_i = 1'b1; mem_pc_i = 32'h40; mem_inst_i = 32'hBBBB_0040;
    push(32'hBBBB_0040, 32'h40);
    step();
    mem_ok_i = 1'b0; if_req_i = 1'b0;
    step();
    req_hit(32'h10, 32'hAAAA_0010);
    // flush coinciding with the matching return: fill, but no response
    if_req_i = 1'b1; if_pc_i = 32'h80;
    step();
    if_req_i = 1'b0;
    flush_i = 1'b1; mem_ok_i = 1'b1; mem_pc_i = 32'h80; mem_inst_i = 32'hCCCC_0080;
    step();
    flush_i = 1'b0; mem_ok_i = 1'b0;
    nc++;
    if (if_ok_o !== 1'b0 || mem_fe_o !== 1'b0) begin
      nm++;
      $display("FAIL flush_with_ok: got if_ok=%b fe=%b, required 0 0", if_ok_o, mem_fe_o);
    end
    step();
    req_hit(32'h80, 32'hCCCC_0080);
  endtask

  // Continuous request on hitting addresses: if_ok must toggle 1,0,1,0
  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] insts [3];
    int k;
    addrs[0] = 32'h0;  insts[0] = 32'h0000_0013;
    addrs[1] = 32'h10; insts[1] = 32'hAAAA_0010;
    addrs[2] = 32'h40; insts[2] = 32'hBBBB_0040;
    k = 0;
    if_req_i = 1'b1; if_pc_i = addrs[0];
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push(insts[k], addrs[k]);
      step();
      nc++;
      if (if_ok_o !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin
        nm++;
        $display("FAIL b2b_pattern[%0d]: got if_ok=%b, required %0d", i, if_ok_o, (i % 2 == 0));
      end
      if (i % 2 == 0) begin
        k = (k + 1) % 3;
        if_pc_i = addrs[k];
      end
    end
    if_req_i = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_miss();
    if_req_i = 1'b1; if_pc_i = 32'h300;
    step();
    nc++;
    if (mem_fe_o !== 1'b1 || mem_fpc_o !== 32'h300) begin
      nm++;
      $display("FAIL pre_reset_miss: got fe=%b fpc=%h, required fe=1 fpc=00000300", mem_fe_o, mem_fpc_o);
    end
    rst_ni = 1'b0;
    if_req_i = 1'b0;
    #1;
    nc++;
    if (if_ok_o !== 1'b0 || if_inst_o !== 32'h0 || if_inst_pc_o !== 32'h0 ||
        mem_fe_o !== 1'b0 || mem_fpc_o !== 32'h0) begin
      nm++;
      $display("FAIL mid_miss_reset: got ok=%b inst=%h ipc=%h fe=%b fpc=%h, required all 0",
               if_ok_o, if_inst_o, if_inst_pc_o, mem_fe_o, mem_fpc_o);
    end
    step();
    rst_ni = 1'b1;
    // late return for the abandoned miss still fills
    mem_ok_i = 1'b1; mem_pc_i = 32'h300; mem_inst_i = 32'hDDDD_0300;
    step();
    mem_ok_i = 1'b0;
    step();
    req_miss(32'h0, 32'h0000_0013);
    req_hit(32'h300, 32'hDDDD_0300);
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_hit();
    test_alias();
    test_flush();
    test_back_to_back();
    test_reset_mid_miss();
    step();
    nc++;
    if (exp_q.size() != 0) begin
      nm++;
      $display("FAIL missing_resp: got %0d undelivered responses, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nm);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the IF stage and `mem_ctrl`. It serves 32-bit instruction fetches from the IF stage with a one-cycle hit latency. On a miss it drives `mem_ctrl`'s instruction-fetch port (`inst_fe`/`inst_fpc`) and fills from `inst_o`/`inst_ok`/`inst_pc`. Each line holds one word; the cache is invalidated only by reset.

## Interface
- `INDEX_W`, default 7: index width; the cache has 2^INDEX_W lines.
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  IF stage requests the instruction at `if_pc`. IF holds `if_req` and `if_pc` stable until `if_ok` or `flush`.
- `if_pc`  in  32  fetch address; bits [1:0] are ignored.
- `flush`  in  1  branch redirect: abandons the outstanding request.
- `if_ok`  out  1  one-cycle pulse: `if_inst`/`if_inst_pc` are valid.
- `if_inst`  out  32  fetched instruction.
- `if_inst_pc`  out  32  address of `if_inst`.
- `mem_fe`  out  1  to `mem_ctrl.inst_fe`; combinational.
- `mem_fpc`  out  32  to `mem_ctrl.inst_fpc`; registered miss address.
- `mem_inst`  in  32  from `mem_ctrl.inst_o`.
- `mem_ok`  in  1  from `mem_ctrl.inst_ok`; one-cycle pulse.
- `mem_pc`  in  32  from `mem_ctrl.inst_pc`.

## Operation
- Address split:
  - index = pc[INDEX_W+1:2]
  - tag = pc[31:INDEX_W+2]
- Per line: a valid bit, tag and data.
- Reset clears only the valid bits; tag and data arrays are not reset.
- States: IDLE, MISS. A 32-bit `miss_pc` register holds the address being fetched.
- Acceptance: an edge where state=IDLE, `if_req`=1, `flush`=0 and `if_ok`=0.
  - The cycle in which `if_ok` is high never accepts a request.
  - Maximum hit throughput is therefore one instruction per 2 cycles.
- Lookup reads the arrays combinationally and sees the contents from before any fill in the same cycle.
  - Hit (valid and tag equal): at the accepting edge `if_ok`<=1, `if_inst`<=data, `if_inst_pc`<=`if_pc`; state stays IDLE.
  - Miss: `miss_pc`<=`if_pc`, state<=MISS.
- `mem_fe` = (state==MISS) && !`flush` && !(`mem_ok` && `mem_pc`==`miss_pc`). `mem_fpc` = `miss_pc`.
  - Dropping `mem_fe` in the `mem_ok` cycle prevents `mem_ctrl` from re-launching the same fetch.
- Fill: at every edge with `mem_ok`=1, the line at index(`mem_pc`) gets valid<=1, tag<=tag(`mem_pc`), data<=`mem_inst`.
  - This holds in any state, including after a flush; the returned word is always correct for `mem_pc`.
- Miss completion: edge with state=MISS, `mem_ok`=1, `mem_pc`==`miss_pc`, `flush`=0. Then:
  - `if_ok`<=1
  - `if_inst`<=`mem_inst`
  - `if_inst_pc`<=`mem_pc`
  - state<=IDLE
- A `mem_ok` whose `mem_pc` differs from `miss_pc` (stale fetch after a redirect) fills the cache only. State stays MISS.
- Flush at an edge: state<=IDLE, `if_ok`<=0, no acceptance that edge.
  - A simultaneous `mem_ok` still fills but produces no response.
  - A new miss after flush presents the new `mem_fpc`; `mem_ctrl` restarts its fetch on the address change.

## Timing
- Reset values:
  - `if_ok`=0, `if_inst`=0, `if_inst_pc`=0
  - `miss_pc`=0, so `mem_fpc`=0
  - state=IDLE, so `mem_fe`=0
- Hit: `if_ok` is high in the cycle after the accepting edge.
- Miss:
  - `mem_fe` rises in the cycle after the accepting edge and stays high until the matching `mem_ok` cycle or a flush.
  - `if_ok` is high in the cycle after the matching `mem_ok` cycle.
- `if_ok` is never high for two consecutive cycles.
- `if_inst`/`if_inst_pc` hold their values between pulses.
- Reset asserted mid-miss: return immediately to IDLE with all valid bits cleared. Any later `mem_ok` fills normally.

## Test plan
- Reset, then `if_req`=1, `if_pc`=0x00000000:
  - Miss; `mem_fe`=1, `mem_fpc`=0x00000000.
  - Drive `mem_ok` with `mem_inst`=0x00000013, `mem_pc`=0x0 → `mem_fe`=0 in that cycle; next cycle `if_ok`=1, `if_inst`=0x00000013, `if_inst_pc`=0x0.
- Re-request 0x00000000 → `if_ok` one cycle after acceptance, `if_inst`=0x00000013, `mem_fe` stays 0.
- With INDEX_W=7, fill 0x00000200 with 0x00100093 (same index as 0x0):
  - Request 0x00000200 → hit 0x00100093.
  - Request 0x00000000 → miss, `mem_fe`=1.
- Miss on 0x00000010, then `flush` for one cycle, then `if_pc`=0x00000040:
  - `mem_fpc` becomes 0x00000040.
  - A stale `mem_ok` with `mem_pc`=0x10 gives no `if_ok` but fills; a later request to 0x10 hits.
- Hold `if_req`=1 continuously on hitting addresses → `if_ok` pattern 1,0,1,0, never back-to-back.
- Pull `rst` low during MISS → all outputs return to reset values, state=IDLE; a request to 0x0 afterwards misses.
